// File: rtl/ram_pkg.sv
// Shared definitions for the ram_hs memory block: transaction FSM states,
// default geometry and the even-parity helper used when RAM_PARITY_EN is set.
package ram_pkg;

    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 8;
    localparam int DEPTH_DEF = 256;

    // Transaction FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Even-parity bit for up to 64 data bits.
    // The caller zero-extends narrower words; zeros do not change the result.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Storage for ram_hs: DEPTH words with one synchronous write port and one
// registered read port sharing a single address.
// Addresses at or above DEPTH read as zero, and writes to them are dropped.
// With RAM_PARITY_EN each word carries an even-parity bit.
// i_pinj inverts the stored parity bit on a write.
// o_perr reports a mismatch on a read and is cleared by a write.
module ram_array
    import ram_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic [DW-1:0] i_wdata,
`ifdef RAM_PARITY_EN
    input  logic          i_pinj,
    output logic          o_perr,
`endif
    input  logic          i_re,
    output logic [DW-1:0] o_rdata
);

`ifdef RAM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif
    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    logic [MW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;
    logic          w_in_range;
    logic [IW-1:0] w_idx;
    logic [MW-1:0] w_wword;
    logic [MW-1:0] w_rword;

    assign w_in_range = ({1'b0, i_addr} < DEPTH_L);
    assign w_idx      = i_addr[IW-1:0];
    assign w_rword    = r_mem[w_idx];
    assign o_rdata    = r_rdata;

`ifdef RAM_PARITY_EN
    logic r_perr;
    assign w_wword = {even_parity(64'(i_wdata)) ^ i_pinj, i_wdata};
    assign o_perr  = r_perr;
`else
    assign w_wword = i_wdata;
`endif

    // Array write: reset has priority, so a write on a reset edge is lost.
    always_ff @(posedge i_clk) begin
        if (i_rstn && i_we && w_in_range) begin
            r_mem[w_idx] <= w_wword;
        end
    end

    // Registered read data (MBR): holds its value until the next read.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_in_range ? w_rword[DW-1:0] : '0;
        end
    end

`ifdef RAM_PARITY_EN
    // Parity error flag: updated by reads, cleared by writes.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_perr <= 1'b0;
        end else if (i_re) begin
            r_perr <= w_in_range &&
                      (even_parity(64'(w_rword[DW-1:0])) != w_rword[DW]);
        end else if (i_we) begin
            r_perr <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/ram_hs.sv
// Single-port RAM behind the MAR/MBR/MFC handshake.
// A transaction starts on a rising edge of enable, sampled in IDLE.
// MAR, rnw and bus are latched when the transaction starts.
// The FSM runs IDLE -> [WAIT] -> ACCESS -> DONE.
// MFC is held high in DONE until the requester drops enable.
// If enable drops before DONE, the access still completes but MFC stays low.
// Optional feature macro: RAM_PARITY_EN. It adds the PINJ and PERR ports and
// per-word parity.
// Handshake contract: the requester raises enable and holds it until MFC is
// seen, then lowers it. MFC falls on the first edge that samples enable low in
// DONE. A new request needs enable to be sampled low in between.
module ram_hs
    import ram_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_STATES = 0
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [AW-1:0] MAR,
    input  logic          enable,
    input  logic          rnw,
    input  logic [DW-1:0] bus,
`ifdef RAM_PARITY_EN
    input  logic          PINJ,
    output logic          PERR,
`endif
    output logic [DW-1:0] MBR,
    output logic          MFC,
    output logic          BUSY,
    output state_t        o_dbg_state
);

    localparam logic [3:0] W_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_en_q;
    logic          r_armed;
    logic          r_mfc;
    logic [AW-1:0] r_addr;
    logic          r_rnw;
    logic [DW-1:0] r_data;
    logic          w_start;
    logic          w_we;
    logic          w_re;

    // r_armed is set only after enable has been sampled low following reset.
    // This stops a level held across reset from starting a transaction.
    assign w_start     = enable && !r_en_q && r_armed;
    assign w_we        = (r_state == ACCESS) && !r_rnw;
    assign w_re        = (r_state == ACCESS) && r_rnw;
    assign MFC         = r_mfc;
    assign BUSY        = (r_state != IDLE);
    assign o_dbg_state = r_state;

    // Next-state logic for the transaction FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (r_cnt == 4'd0) w_next = ACCESS;
            ACCESS:  w_next = enable ? DONE : IDLE;
            DONE:    if (!enable) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register, enable history, wait counter, request latch and MFC.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_en_q  <= 1'b0;
            r_armed <= 1'b0;
            r_mfc   <= 1'b0;
            r_addr  <= '0;
            r_rnw   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            r_en_q  <= enable;
            if (!enable) begin
                r_armed <= 1'b1;
            end
            if (r_state == IDLE && w_start) begin
                r_addr <= MAR;
                r_rnw  <= rnw;
                r_data <= bus;
                r_cnt  <= W_LOAD;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == ACCESS && enable) begin
                r_mfc <= 1'b1;
            end else if (r_state == DONE && !enable) begin
                r_mfc <= 1'b0;
            end
        end
    end

    ram_array #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_array (
        .i_clk   (CLK),
        .i_rstn  (RSTN),
        .i_addr  (r_addr),
        .i_we    (w_we),
        .i_wdata (r_data),
`ifdef RAM_PARITY_EN
        .i_pinj  (PINJ),
        .o_perr  (PERR),
`endif
        .i_re    (w_re),
        .o_rdata (MBR)
    );

endmodule

// File: tb/tb_ram_hs.sv
// Testbench for ram_hs: two instances (W=0/DEPTH=256 and W=3/DEPTH=200),
// a memory reference model, and an MFC-triggered scoreboard on MBR.
// Honours RAM_PARITY_EN when defined.
module tb_ram_hs;
    import ram_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic [1:0][7:0] mar, bus, mbr;
    logic [1:0]      en, rnw, mfc, busy;
`ifdef RAM_PARITY_EN
    logic [1:0]      pinj, perr;
`endif
    state_t dbg0, dbg1;

    ram_hs #(.DW(8), .AW(8), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .CLK(clk), .RSTN(rstn), .MAR(mar[0]), .enable(en[0]), .rnw(rnw[0]),
        .bus(bus[0]),
`ifdef RAM_PARITY_EN
        .PINJ(pinj[0]), .PERR(perr[0]),
`endif
        .MBR(mbr[0]), .MFC(mfc[0]), .BUSY(busy[0]), .o_dbg_state(dbg0));

    ram_hs #(.DW(8), .AW(8), .DEPTH(200), .WAIT_STATES(3)) dut1 (
        .CLK(clk), .RSTN(rstn), .MAR(mar[1]), .enable(en[1]), .rnw(rnw[1]),
        .bus(bus[1]),
`ifdef RAM_PARITY_EN
        .PINJ(pinj[1]), .PERR(perr[1]),
`endif
        .MBR(mbr[1]), .MFC(mfc[1]), .BUSY(busy[1]), .o_dbg_state(dbg1));

    // ---------------- reference model ----------------
    int checks = 0;
    int failures = 0;
    logic [7:0] model    [2][256];
    logic       inj_mdl  [2][256];
    logic [7:0] last_mbr [2];
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    function automatic int depth_of(input int d);
        return (d == 0) ? 256 : 200;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input logic [7:0] v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    // ---------------- scoreboard monitor ----------------
    // On every rising MFC, the next expected MBR value is popped and compared.
    initial begin : monitor
        logic [1:0] prev;
        logic [7:0] e;
        prev = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (mfc[d] && !prev[d]) begin
                    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                        chk("sb_unexpected_mfc", 32'(d), 32'hFFFF);
                    end else begin
                        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk((d == 0) ? "sb_mbr_dut0" : "sb_mbr_dut1", 32'(mbr[d]), 32'(e));
                    end
                end
            end
            prev = mfc;
        end
    end

    // ---------------- driver tasks ----------------
    // Full handshake. Checks BUSY, the MFC latency (the start edge counts as
    // edge 1) and the MFC drop. If chg is set, the inputs are scrambled
    // after the start edge.
    task automatic txn(input int d, input bit rd, input logic [7:0] a,
                       input logic [7:0] wd, input bit pj, input bit chg);
        int  n;
        bit  got;
        bit  inr;
        logic [7:0] v;
        logic       ep;
        inr = (int'(a) < depth_of(d));
        @(negedge clk);
        mar[d] = a; rnw[d] = rd; bus[d] = wd; en[d] = 1'b1;
`ifdef RAM_PARITY_EN
        pinj[d] = pj;
`endif
        ep = 1'b0;
        if (rd) begin
            v  = inr ? model[d][a] : 8'h00;
            ep = inr ? inj_mdl[d][a] : 1'b0;
            last_mbr[d] = v;
        end else if (inr) begin
            model[d][a]   = wd;
            inj_mdl[d][a] = pj;
        end
        push_exp(d, last_mbr[d]);
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                chk("busy_in_txn", 32'(busy[d]), 32'd1);
                if (chg) begin
                    mar[d] = 8'h05; bus[d] = ~wd; rnw[d] = ~rd;
                end
            end
            if (mfc[d]) got = 1'b1;
        end
        chk("mfc_seen", 32'(got), 32'd1);
        chk("mfc_latency", 32'(n), 32'(ws_of(d) + 2));
`ifdef RAM_PARITY_EN
        if (rd) chk("perr", 32'(perr[d]), 32'(ep));
        else    chk("perr_wr_clear", 32'(perr[d]), 32'd0);
`endif
        @(negedge clk);
        en[d] = 1'b0;
`ifdef RAM_PARITY_EN
        pinj[d] = 1'b0;
`endif
        @(posedge clk); #1;
        chk("mfc_drop", 32'(mfc[d]), 32'd0);
        chk("busy_drop", 32'(busy[d]), 32'd0);
    endtask

    // Write whose enable falls after the start edge: commits, no MFC.
    task automatic drop_write(input int d, input logic [7:0] a, input logic [7:0] wd);
        bit seen;
        @(negedge clk);
        mar[d] = a; rnw[d] = 1'b0; bus[d] = wd; en[d] = 1'b1;
        @(posedge clk); #1;
        chk("drop_busy", 32'(busy[d]), 32'd1);
        @(negedge clk);
        en[d] = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (mfc[d]) seen = 1'b1;
        end
        chk("drop_no_mfc", 32'(seen), 32'd0);
        chk("drop_busy_idle", 32'(busy[d]), 32'd0);
        if (int'(a) < depth_of(d)) begin
            model[d][a]   = wd;
            inj_mdl[d][a] = 1'b0;
        end
    endtask

    // Pick an address from 0..15 or 195..215 (around the DEPTH=200 edge).
    function automatic logic [7:0] pick_addr();
        if ($urandom_range(0, 1) == 0) return 8'($urandom_range(0, 15));
        return 8'($urandom_range(195, 215));
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        bit bad_busy, bad_mfc;
        rstn = 1'b0;
        en = '0; rnw = '0; mar = '0; bus = '0;
`ifdef RAM_PARITY_EN
        pinj = '0;
`endif
        last_mbr[0] = 8'h00; last_mbr[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_mbr", 32'(mbr[d]), 32'd0);
            chk("rst_mfc", 32'(mfc[d]), 32'd0);
            chk("rst_busy", 32'(busy[d]), 32'd0);
        end
        chk("rst_state0", 32'(dbg0), 32'(IDLE));
        chk("rst_state1", 32'(dbg1), 32'(IDLE));
        @(negedge clk);
        rstn = 1'b1;

        // Preload the address pool so every later read has a known value.
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 216; a++) begin
                if (a < 16 || a >= 195)
                    txn(d, 1'b0, 8'(a), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            end
        end

        // W=0 directed write then read.
        txn(0, 1'b0, 8'h01, 8'h48, 1'b0, 1'b0);
        txn(0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
        chk("dir_mbr_48", 32'(mbr[0]), 32'h48);

        // W=3 read with MAR/rnw/bus disturbed during WAIT.
        txn(1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);

        // DEPTH=200 out-of-range write/read and the no-alias check.
        txn(1, 1'b0, 8'd210, 8'hAA, 1'b0, 1'b0);
        txn(1, 1'b1, 8'd210, 8'h00, 1'b0, 1'b0);
        chk("oor_mbr_zero", 32'(mbr[1]), 32'd0);
        txn(1, 1'b1, 8'd199, 8'h00, 1'b0, 1'b0);

        // Early drop of enable during WAIT: the write still commits.
        drop_write(1, 8'h07, 8'h3C);
        txn(1, 1'b1, 8'h07, 8'h00, 1'b0, 1'b0);

        // Reset while a write sits in WAIT: the old value survives.
        @(negedge clk);
        mar[1] = 8'h08; rnw[1] = 1'b0; bus[1] = ~model[1][8]; en[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rstn = 1'b0; en[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        last_mbr[0] = 8'h00; last_mbr[1] = 8'h00;
        txn(1, 1'b1, 8'h08, 8'h00, 1'b0, 1'b0);

        // enable held high through reset release: no transaction.
        @(negedge clk);
        rstn = 1'b0;
        mar[0] = 8'h03; rnw[0] = 1'b0; bus[0] = ~model[0][3]; en[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        last_mbr[0] = 8'h00; last_mbr[1] = 8'h00;
        bad_busy = 1'b0; bad_mfc = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy[0]) bad_busy = 1'b1;
            if (mfc[0])  bad_mfc  = 1'b1;
        end
        chk("held_no_busy", 32'(bad_busy), 32'd0);
        chk("held_no_mfc", 32'(bad_mfc), 32'd0);
        @(negedge clk);
        en[0] = 1'b0;
        txn(0, 1'b1, 8'h03, 8'h00, 1'b0, 1'b0);

`ifdef RAM_PARITY_EN
        // Parity injection and recovery.
        txn(0, 1'b0, 8'h20, 8'h0F, 1'b1, 1'b0);
        txn(0, 1'b1, 8'h20, 8'h00, 1'b0, 1'b0);
        chk("par_mbr", 32'(mbr[0]), 32'h0F);
        chk("par_err_set", 32'(perr[0]), 32'd1);
        txn(0, 1'b0, 8'h20, 8'h0F, 1'b0, 1'b0);
        txn(0, 1'b1, 8'h20, 8'h00, 1'b0, 1'b0);
        chk("par_err_clr", 32'(perr[0]), 32'd0);
`endif

        // Randomised traffic on both instances.
        for (int i = 0; i < 80; i++) begin
            txn(i % 2, 1'($urandom_range(0, 1)), pick_addr(),
                8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_q0_empty", 32'(exp_q0.size()), 32'd0);
        chk("sb_q1_empty", 32'(exp_q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_hs.md
Name: ram_hs

Overview:
- Parametrised single-port synchronous RAM behind the processor's MAR/MBR/MFC memory handshake; successor to the fixed 256x8 data/program store.
- Width, depth and access wait states are configurable.
- Fully clocked transaction FSM with reset; no asynchronous edge sensing of `enable`.
- Sits between the control unit (drives MAR, enable, rnw, bus) and the datapath (consumes MBR, waits on MFC).

Parameters:
- DW, 8, data word width in bits (>=1).
- AW, 8, address width in bits (>=1).
- DEPTH, 256, implemented words (1..2**AW).
- WAIT_STATES, 0, extra cycles inserted before the array access (0..15).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RSTN  in  1  synchronous active-low reset.
- MAR  in  AW  word address.
- enable  in  1  transaction request; level-held by the requester until MFC is seen.
- rnw  in  1  1 = read, 0 = write.
- bus  in  DW  write data.
- MBR  out  DW  read data register.
- MFC  out  1  memory-function-complete.
- BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (RSTN=0 at a CLK edge): MBR=0, MFC=0, BUSY=0, state=IDLE, wait counter=0, enable_q=0. Array contents are not cleared.
- Start condition: `enable && !enable_q` sampled in IDLE, where enable_q is enable registered each cycle. A level held high across reset does not start a transaction until it falls and rises again.
- On start: latch MAR, rnw and bus into internal registers. Next state is WAIT if WAIT_STATES>0, otherwise ACCESS. Later changes to MAR, rnw or bus are ignored.
- WAIT: counter loaded with WAIT_STATES-1 and decremented each cycle; go to ACCESS when it reaches 0.
- ACCESS (one cycle):
  - Read: MBR <= mem[addr].
  - Write: mem[addr] <= data; MBR unchanged.
  - Both: MFC <= 1, then go to DONE.
- DONE: hold MFC=1 while enable=1. When enable=0 is sampled, MFC <= 0 and go to IDLE.
- Latency: MFC is first high after the edge W+1 cycles after the start edge (W=WAIT_STATES). W=0 means MFC rises 2 edges after enable is first sampled high.
- MBR holds its value indefinitely until the next read's ACCESS cycle.
- Early drop: if enable falls before DONE, the transaction still completes and any write is committed. MFC is not raised; the FSM returns directly from ACCESS to IDLE.
- Out of range (addr >= DEPTH): a read loads MBR=0, a write is discarded. The handshake still completes normally, with MFC asserted.
- Reset mid-transaction: any write not yet in its ACCESS cycle is lost. A write whose ACCESS edge coincides with RSTN=0 is also lost, because reset has priority.
- Back-to-back: a new transaction needs enable low for at least one sampled cycle after DONE.

Optional Feature:
- Macro: RAM_PARITY_EN.
- When defined:
  - Each word stores one extra even-parity bit.
  - Extra input port PINJ (1 bit): when high during a write's ACCESS cycle, the stored parity bit is inverted.
  - Extra output PERR (1 bit, reset 0): on a read's ACCESS cycle, PERR <= parity mismatch. It updates alongside MBR; writes clear it.
- When not defined: no PINJ/PERR ports and no parity storage; behaviour is otherwise identical.

Decomposition:
- Package ram_pkg:
  - State enum {IDLE, WAIT, ACCESS, DONE} (2 bits).
  - Default constants DW_DEF=8, AW_DEF=8, DEPTH_DEF=256.
  - Function for even parity.
- Sub-module ram_array:
  - Storage only: DEPTH x (DW + parity) words, one synchronous write port and one synchronous read port, range check included.
  - ram_hs instantiates it and owns the FSM, latching and MFC.

Test Plan:
- W=0: write 8'h48 to 8'h01, then read 8'h01 -> MBR=8'h48; MFC rises 2 edges after enable is sampled; BUSY is high during the transaction.
- WAIT_STATES=3: read 8'h00 -> MFC rises exactly 5 edges after the start edge; MAR changed to 8'h05 during WAIT does not change the data returned.
- DEPTH=200: write 8'hAA to 8'd210, then read 8'd210 -> MBR=0 and MFC asserted. A follow-up read of 8'd199 returns its prior value, i.e. the discarded write did not alias.
- Write, then drop enable during WAIT -> MFC never rises, BUSY returns to 0, and a later read shows the write committed. Reset asserted in WAIT on a different write -> later read shows the old value.
- enable held high through reset release -> no transaction occurs. A subsequent 0->1 on enable -> normal completion.
- With RAM_PARITY_EN: write 8'h0F with PINJ=1, then read -> MBR=8'h0F and PERR=1. Rewrite with PINJ=0, then read -> PERR=0.
